pc_next_predict: RTL and testbench
==================================

# pc_next_predict

Parametrised successor to the RISC PC-select mux (mux C). Chooses the next PC from incremented PC, predicted branch target, branch address (BrA) or register jump address (RAA), and owns the PC register. Adds a direct-mapped table of 2-bit saturating counters to predict conditional branches at fetch, resolves them at execute, and issues a redirect plus one-cycle flush on misprediction. Sits between fetch (PC consumer) and execute (BS/PS/Z producer).

## Interface
- PC_W, 16, PC and target width
- ADDR_W, 32, width of BrA/RAA; low PC_W bits used
- BHT_DEPTH, 16, counter entries, power of 2, ≥2
- RESET_PC, 0, PC value after reset

- CLK  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; 0 = in reset
- stall  in  1  hold PC and prediction
- pc_inc  in  PC_W  PC+1 from fetch
- fetch_is_branch  in  1  predecode: fetch instruction is conditional branch (BS=01)
- fetch_target  in  PC_W  predecoded branch target of fetch instruction
- ex_valid  in  1  EX stage holds a valid instruction
- ex_pc  in  PC_W  PC of EX instruction
- ex_predicted  in  1  branch_predict value carried down with EX instruction
- BS  in  2  branch select of EX instruction
- PS  in  1  polarity select
- Z  in  1  zero flag
- BrA  in  ADDR_W  branch address
- RAA  in  ADDR_W  register A (jump-register) address
- PC  out  PC_W  registered program counter
- branch_predict  out  1  prediction for current fetch (combinational)
- flush  out  1  registered; kill fetch/decode instructions

## Operation
- BS decode: 00 no control transfer; 01 conditional, taken = Z ^ PS (PS=0 BZ, PS=1 BNZ); 10 jump to RAA[PC_W-1:0]; 11 jump to BrA[PC_W-1:0].
- Index: idx = PC[log2(BHT_DEPTH)-1:0] at fetch, ex_pc[same bits] at update.
- branch_predict = fetch_is_branch & bht[idx][1]; 0 in reset and without BHT.
- Redirect condition (ex_valid=1 only): BS=10 or 11; or BS=01 and taken != ex_predicted. Target: RAA, BrA, BrA (taken) or ex_pc+1 (not taken, wraps mod 2^PC_W).
- Next-PC priority per edge: redirect > stall (hold) > branch_predict (fetch_target) > pc_inc.
- flush <= redirect, high exactly one cycle after the redirecting cycle, coinciding with PC = corrected target.
- BHT update when ex_valid & BS=01, independent of stall: taken → saturating increment (max 11), not taken → saturating decrement (min 00). ex_valid=0 or BS≠01: no update.
- Same-cycle fetch read and EX write of same idx: fetch sees old value.
- ex_predicted ignored when BS≠01.

## Timing
- Reset (async assert, sync release on CLK): PC=RESET_PC, flush=0, all counters 01 (weakly not-taken).
- Reset mid-redirect: PC=RESET_PC, flush=0 immediately; pending redirect discarded.
- Correct prediction: zero penalty. Mispredict/jump: PC correct next edge; flush one cycle; 2-instruction penalty.
- Redirect during stall: redirect wins, PC updates, flush asserts.
- Back-to-back redirects: each updates PC; flush stays high for consecutive cycles.
- PC arithmetic unsigned mod 2^PC_W; BrA/RAA upper bits ignored.

## Configuration
- PC_PRED_BHT_EN defined: counter table as above.
- Undefined: no table, static predict-not-taken; branch_predict tied 0; redirect on every taken BS=01 and every BS=10/11; no counter storage synthesised.

## Structure
- Package pc_pred_pkg: BS encodings (BS_INC=2'b00, BS_COND=2'b01, BS_JR=2'b10, BS_JMP=2'b11), 2-bit counter type, counter constants (SNT=00, WNT=01, WT=10, ST=11), reset counter value WNT.
- Sub-module bht_2bit: BHT_DEPTH counters, one async read port, one saturating update port, async active-low reset; instantiated only under PC_PRED_BHT_EN.

## Test plan
- Reset: reset=0 mid-run → PC=0, flush=0, branch_predict=0 with fetch_is_branch=1; release → PC follows pc_inc.
- Sequential: BS=00, pc_inc=1,2,3 → PC=1,2,3, flush never asserts; stall=1 → PC holds.
- Training: ex_pc=4, BS=01, PS=0, Z=1, ex_valid=1, ex_predicted=0 twice → first mispredict redirects PC=BrA, flush=1; counter 01→10→11; then PC=4, fetch_is_branch=1 → branch_predict=1, PC=fetch_target next edge.
- Not-taken mispredict: ex_predicted=1, BS=01, PS=1, Z=1, ex_pc=16'hFFFF → PC=16'h0000 (wrap), flush=1.
- Jumps: BS=10, RAA=32'hABCD_0012 → PC=16'h0012; BS=11, BrA=1 with stall=1 → PC=1, flush=1.
- Saturation/collision: six not-taken updates to idx 3 → counter stays 00; same-cycle fetch at idx 3 sees pre-update value.

Source files
------------

// File: rtl/pc_pred_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_pred_pkg
// Purpose  : Shared encodings for the next-PC selector and its branch
//            history table: branch-select codes, 2-bit counter type,
//            counter state constants and the saturating update helper.
// Revision : 1.0 - initial release
// ============================================================================
package pc_pred_pkg;

  // Branch select encodings carried by the EX instruction
  typedef enum logic [1:0] {
    BS_INC  = 2'b00,  // no control transfer
    BS_COND = 2'b01,  // conditional branch, taken = Z ^ PS
    BS_JR   = 2'b10,  // jump to register address (RAA)
    BS_JMP  = 2'b11   // jump to branch address (BrA)
  } bs_e;

  // 2-bit saturating counter; bit 1 is the taken prediction
  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT       = 2'b00;  // strongly not-taken
  localparam ctr_t WNT       = 2'b01;  // weakly not-taken
  localparam ctr_t WT        = 2'b10;  // weakly taken
  localparam ctr_t ST        = 2'b11;  // strongly taken
  localparam ctr_t CTR_RESET = WNT;

  // Saturating step toward the resolved outcome
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    if (taken) begin
      if (c != ST) n = c + 2'b01;
    end else begin
      if (c != SNT) n = c - 2'b01;
    end
    return n;
  endfunction

endpackage : pc_pred_pkg
`default_nettype wire

// File: rtl/bht_2bit.sv
`default_nettype none
// ============================================================================
// Module   : bht_2bit
// Purpose  : Direct-mapped table of 2-bit saturating counters. One
//            asynchronous read port (fetch) and one saturating update port
//            (execute). A read of the entry being updated in the same cycle
//            returns the value held before the update.
// Ports    : clk         - clock, rising edge
//            rst_n       - asynchronous active-low reset, all entries -> WNT
//            i_rd_idx    - fetch read index
//            o_rd_ctr    - counter at i_rd_idx
//            i_upd_en    - apply an update this cycle
//            i_upd_idx   - entry to update
//            i_upd_taken - resolved outcome (1 = increment, 0 = decrement)
// Revision : 1.0 - initial release
// ============================================================================
module bht_2bit
  import pc_pred_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output ctr_t             o_rd_ctr,
  input  logic             i_upd_en,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken
);

  ctr_t r_ctr [DEPTH];

  assign o_rd_ctr = r_ctr[i_rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ctr[i] <= CTR_RESET;
      end
    end else if (i_upd_en) begin
      r_ctr[i_upd_idx] <= ctr_next(r_ctr[i_upd_idx], i_upd_taken);
    end
  end

endmodule : bht_2bit
`default_nettype wire

// File: rtl/pc_next_predict.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_predict
// Purpose  : Next-PC selector owning the PC register. Chooses between the
//            incremented PC, a predicted branch target, BrA or RAA; resolves
//            conditional branches at execute and issues a redirect plus a
//            one-cycle flush whenever the fetch path went the wrong way.
// Config   : PC_PRED_BHT_EN defined   -> 2-bit counter table predicts
//                                        conditional branches at fetch.
//            PC_PRED_BHT_EN undefined -> static predict-not-taken, no table.
// Ports    : CLK             - clock, rising edge
//            reset           - asynchronous active-low reset
//            stall           - hold PC (a redirect still wins)
//            pc_inc          - PC+1 from fetch
//            fetch_is_branch - fetch instruction is a conditional branch
//            fetch_target    - predecoded target of fetch instruction
//            ex_valid        - EX stage holds a valid instruction
//            ex_pc           - PC of EX instruction
//            ex_predicted    - prediction carried down with EX instruction
//            BS, PS, Z       - branch select, polarity, zero flag
//            BrA, RAA        - branch / register jump address (low PC_W used)
//            PC              - registered program counter
//            branch_predict  - combinational prediction for current fetch
//            flush           - registered, kill fetch/decode instructions
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_predict
  import pc_pred_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter int              ADDR_W    = 32,
  parameter int              BHT_DEPTH = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              stall,
  input  logic [PC_W-1:0]   pc_inc,
  input  logic              fetch_is_branch,
  input  logic [PC_W-1:0]   fetch_target,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_predicted,
  input  logic [1:0]        BS,
  input  logic              PS,
  input  logic              Z,
  input  logic [ADDR_W-1:0] BrA,
  input  logic [ADDR_W-1:0] RAA,
  output logic [PC_W-1:0]   PC,
  output logic              branch_predict,
  output logic              flush
);

  logic [PC_W-1:0] r_pc;
  logic            r_flush;

  logic            w_taken;
  logic            w_ex_pred_eff;
  logic            w_redirect;
  logic [PC_W-1:0] w_redirect_pc;
  logic [PC_W-1:0] w_ex_pc_inc;
  logic [PC_W-1:0] w_next_pc;
  logic            w_unused;

  assign w_taken     = Z ^ PS;
  // Fall-through address of the EX branch; wraps naturally at PC_W bits
  assign w_ex_pc_inc = ex_pc + {{(PC_W-1){1'b0}}, 1'b1};

`ifdef PC_PRED_BHT_EN
  localparam int IDX_W = $clog2(BHT_DEPTH);

  ctr_t w_fetch_ctr;

  bht_2bit #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk         (CLK),
    .rst_n       (reset),
    .i_rd_idx    (r_pc[IDX_W-1:0]),
    .o_rd_ctr    (w_fetch_ctr),
    .i_upd_en    (ex_valid && (bs_e'(BS) == BS_COND)),
    .i_upd_idx   (ex_pc[IDX_W-1:0]),
    .i_upd_taken (w_taken)
  );

  assign branch_predict = fetch_is_branch & w_fetch_ctr[1] & reset;
  assign w_ex_pred_eff  = ex_predicted;
  assign w_unused       = ^{BrA, RAA};
`else
  // Static not-taken: whatever arrives on ex_predicted, fetch never
  // followed a branch target, so every taken conditional must redirect.
  assign branch_predict = 1'b0;
  assign w_ex_pred_eff  = 1'b0;
  assign w_unused       = ^{BrA, RAA, ex_predicted, fetch_is_branch, fetch_target};
`endif

  // Execute-stage resolution
  always_comb begin
    w_redirect    = 1'b0;
    w_redirect_pc = w_ex_pc_inc;
    if (ex_valid) begin
      case (bs_e'(BS))
        BS_JR: begin
          w_redirect    = 1'b1;
          w_redirect_pc = RAA[PC_W-1:0];
        end
        BS_JMP: begin
          w_redirect    = 1'b1;
          w_redirect_pc = BrA[PC_W-1:0];
        end
        BS_COND: begin
          if (w_taken != w_ex_pred_eff) begin
            w_redirect    = 1'b1;
            w_redirect_pc = w_taken ? BrA[PC_W-1:0] : w_ex_pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Priority: redirect > stall > predicted target > sequential
  always_comb begin
    w_next_pc = pc_inc;
    if (w_redirect) begin
      w_next_pc = w_redirect_pc;
    end else if (stall) begin
      w_next_pc = r_pc;
    end else if (branch_predict) begin
      w_next_pc = fetch_target;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_pc    <= RESET_PC;
      r_flush <= 1'b0;
    end else begin
      r_pc    <= w_next_pc;
      r_flush <= w_redirect;
    end
  end

  assign PC    = r_pc;
  assign flush = r_flush;

endmodule : pc_next_predict
`default_nettype wire

// File: tb/tb_pc_next_predict.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_next_predict
// Purpose  : Directed self-checking bench for pc_next_predict. Expected
//            values are hand-computed; where the counter table changes the
//            outcome both variants are listed and picked by PC_PRED_BHT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_next_predict;

`ifdef PC_PRED_BHT_EN
  localparam bit BHT = 1'b1;
`else
  localparam bit BHT = 1'b0;
`endif

  logic        CLK;
  logic        reset;
  logic        stall;
  logic [15:0] pc_inc;
  logic        fetch_is_branch;
  logic [15:0] fetch_target;
  logic        ex_valid;
  logic [15:0] ex_pc;
  logic        ex_predicted;
  logic [1:0]  BS;
  logic        PS;
  logic        Z;
  logic [31:0] BrA;
  logic [31:0] RAA;
  logic [15:0] PC;
  logic        branch_predict;
  logic        flush;

  int checks = 0;
  int errors = 0;

  pc_next_predict #(
    .PC_W      (16),
    .ADDR_W    (32),
    .BHT_DEPTH (16),
    .RESET_PC  (16'h0000)
  ) dut (
    .CLK             (CLK),
    .reset           (reset),
    .stall           (stall),
    .pc_inc          (pc_inc),
    .fetch_is_branch (fetch_is_branch),
    .fetch_target    (fetch_target),
    .ex_valid        (ex_valid),
    .ex_pc           (ex_pc),
    .ex_predicted    (ex_predicted),
    .BS              (BS),
    .PS              (PS),
    .Z               (Z),
    .BrA             (BrA),
    .RAA             (RAA),
    .PC              (PC),
    .branch_predict  (branch_predict),
    .flush           (flush)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle past it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; pc_inc = '0; fetch_is_branch = 1'b0;
    fetch_target = '0; ex_valid = 1'b0; ex_pc = '0; ex_predicted = 1'b0;
    BS = 2'b00; PS = 1'b0; Z = 1'b0; BrA = '0; RAA = '0;

    // ---- reset state ----
    tick(); tick();
    chk("rst_pc", {16'h0, PC}, 32'h0);
    chk("rst_flush", {31'h0, flush}, 32'h0);
    fetch_is_branch = 1'b1; #1;
    chk("rst_bp", {31'h0, branch_predict}, 32'h0);
    fetch_is_branch = 1'b0;
    reset = 1'b1;

    // ---- sequential ----
    pc_inc = 16'h0001; tick();
    chk("seq_pc1", {16'h0, PC}, 32'h1);
    pc_inc = 16'h0002; tick();
    chk("seq_pc2", {16'h0, PC}, 32'h2);
    pc_inc = 16'h0003; tick();
    chk("seq_pc3", {16'h0, PC}, 32'h3);
    chk("seq_flush", {31'h0, flush}, 32'h0);
    stall = 1'b1; pc_inc = 16'h0009; tick();
    chk("stall_pc", {16'h0, PC}, 32'h3);
    stall = 1'b0;

    // ---- training: taken branch at ex_pc=4, predicted not-taken twice ----
    ex_valid = 1'b1; ex_pc = 16'h0004; BS = 2'b01; PS = 1'b0; Z = 1'b1;
    ex_predicted = 1'b0; BrA = 32'h0000_0040; pc_inc = 16'h0004;
    tick();
    chk("train1_pc", {16'h0, PC}, 32'h40);
    chk("train1_flush", {31'h0, flush}, 32'h1);
    tick();
    chk("train2_pc", {16'h0, PC}, 32'h40);
    chk("train2_flush", {31'h0, flush}, 32'h1);
    ex_valid = 1'b0; tick();
    chk("train3_pc", {16'h0, PC}, 32'h4);
    chk("train3_flush", {31'h0, flush}, 32'h0);
    fetch_is_branch = 1'b1; fetch_target = 16'h0100; pc_inc = 16'h0005; #1;
    chk("pred_bp", {31'h0, branch_predict}, BHT ? 32'h1 : 32'h0);
    tick();
    chk("pred_pc", {16'h0, PC}, BHT ? 32'h100 : 32'h5);
    fetch_is_branch = 1'b0;

    // ---- not-taken mispredict with fall-through wrap ----
    ex_valid = 1'b1; ex_pc = 16'hFFFF; BS = 2'b01; PS = 1'b1; Z = 1'b1;
    ex_predicted = 1'b1; pc_inc = 16'h0101;
    tick();
    chk("nt_pc", {16'h0, PC}, BHT ? 32'h0 : 32'h101);
    chk("nt_flush", {31'h0, flush}, BHT ? 32'h1 : 32'h0);

    // ---- jumps ----
    BS = 2'b10; RAA = 32'hABCD_0012; ex_predicted = 1'b0; tick();
    chk("jr_pc", {16'h0, PC}, 32'h12);
    chk("jr_flush", {31'h0, flush}, 32'h1);
    BS = 2'b11; BrA = 32'h0000_0001; stall = 1'b1; tick();
    chk("jmp_stall_pc", {16'h0, PC}, 32'h1);
    chk("jmp_stall_flush", {31'h0, flush}, 32'h1);
    ex_valid = 1'b0; tick();
    chk("hold_pc", {16'h0, PC}, 32'h1);
    chk("hold_flush", {31'h0, flush}, 32'h0);
    stall = 1'b0; pc_inc = 16'h0022; tick();
    chk("inv_jmp_pc", {16'h0, PC}, 32'h22);
    chk("inv_jmp_flush", {31'h0, flush}, 32'h0);

    // ---- taken branch predicted taken: correct with table, redirect without ----
    ex_valid = 1'b1; ex_pc = 16'h0008; BS = 2'b01; PS = 1'b0; Z = 1'b1;
    ex_predicted = 1'b1; BrA = 32'h0000_0077; pc_inc = 16'h0030;
    tick();
    chk("ptk_pc", {16'h0, PC}, BHT ? 32'h30 : 32'h77);
    chk("ptk_flush", {31'h0, flush}, BHT ? 32'h0 : 32'h1);

    ex_valid = 1'b0; BS = 2'b00; pc_inc = 16'h0003; tick();
    chk("idx3_pc", {16'h0, PC}, 32'h3);

`ifdef PC_PRED_BHT_EN
    // ---- saturation / same-cycle collision at idx 3, PC held at 3 ----
    stall = 1'b1; fetch_is_branch = 1'b1;
    ex_valid = 1'b1; ex_pc = 16'h0003; BS = 2'b01; PS = 1'b0;
    Z = 1'b1; ex_predicted = 1'b1; #1;           // taken, agreed: no redirect
    chk("col_bp_old01", {31'h0, branch_predict}, 32'h0);
    tick();
    chk("col_pc", {16'h0, PC}, 32'h3);
    chk("col_bp_10", {31'h0, branch_predict}, 32'h1);
    Z = 1'b0; ex_predicted = 1'b0; #1;           // not-taken, agreed
    chk("col_bp_old10", {31'h0, branch_predict}, 32'h1);
    tick();
    chk("sat_bp_01", {31'h0, branch_predict}, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_pc", {16'h0, PC}, 32'h3);
    chk("sat_flush", {31'h0, flush}, 32'h0);
    Z = 1'b1; ex_predicted = 1'b1; tick();       // 00 -> 01
    chk("sat_bp_up1", {31'h0, branch_predict}, 32'h0);
    tick();                                      // 01 -> 10
    chk("sat_bp_up2", {31'h0, branch_predict}, 32'h1);
`else
    // ---- static predict: fetch branches never predicted taken ----
    stall = 1'b1; fetch_is_branch = 1'b1; #1;
    chk("static_bp", {31'h0, branch_predict}, 32'h0);
    ex_valid = 1'b1; ex_pc = 16'h0003; BS = 2'b01; PS = 1'b0;
    Z = 1'b0; ex_predicted = 1'b1; tick();       // not taken: no redirect
    chk("static_nt_pc", {16'h0, PC}, 32'h3);
    chk("static_nt_flush", {31'h0, flush}, 32'h0);
`endif

    // ---- reset in the middle of a redirect ----
    stall = 1'b0; fetch_is_branch = 1'b0;
    ex_valid = 1'b1; BS = 2'b10; RAA = 32'h0000_0055; tick();
    chk("pre_rst_pc", {16'h0, PC}, 32'h55);
    chk("pre_rst_flush", {31'h0, flush}, 32'h1);
    reset = 1'b0; #1;
    chk("mid_rst_pc", {16'h0, PC}, 32'h0);
    chk("mid_rst_flush", {31'h0, flush}, 32'h0);
    tick();
    chk("in_rst_pc", {16'h0, PC}, 32'h0);
    reset = 1'b1; ex_valid = 1'b0; BS = 2'b00; pc_inc = 16'h0003; tick();
    chk("post_rst_pc", {16'h0, PC}, 32'h3);
    chk("post_rst_flush", {31'h0, flush}, 32'h0);
    fetch_is_branch = 1'b1; #1;
    chk("post_rst_bp", {31'h0, branch_predict}, 32'h0);
    fetch_is_branch = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pc_next_predict
`default_nettype wire
